// File: rtl/dsp_pkg.sv
// Shared DSP helpers: accumulator width rule and legal block-length range.
package dsp_pkg;

    localparam int LOG2N_MIN = 1;
    localparam int LOG2N_MAX = 8;

    function automatic int acc_width(input int iw, input int log2n);
        return iw + log2n;
    endfunction

endpackage

// File: rtl/signed_adder.sv
// Combinational two's-complement adder; result is one bit wider than the wider operand.
module signed_adder #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    localparam int SWIDTH = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1
) (
    input  logic signed [AWIDTH-1:0] i_a,
    input  logic signed [BWIDTH-1:0] i_b,
    output logic signed [SWIDTH-1:0] o_sum
);

    always_comb begin
        o_sum = SWIDTH'(i_a) + SWIDTH'(i_b);
    end

endmodule

// File: rtl/signed_acc_dump.sv
// Integrate-and-dump over blocks of 2^LOG2N signed samples with valid/ready on both sides.
// Define SIGNED_ACC_DUMP_MEAN_EN to emit the rounded block mean instead of the full sum.
module signed_acc_dump
    import dsp_pkg::*;
#(
    parameter int IWIDTH = 17,
    parameter int LOG2N  = 4,
    localparam int AW    = acc_width(IWIDTH, LOG2N),
`ifdef SIGNED_ACC_DUMP_MEAN_EN
    localparam int OWIDTH = IWIDTH
`else
    localparam int OWIDTH = AW
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [IWIDTH-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_clear,
    output logic signed [OWIDTH-1:0] o_data,
    output logic                     o_valid,
    input  logic                     i_ready
);

    generate
        if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX) begin : g_bad_log2n
            $error("signed_acc_dump: LOG2N out of range");
        end
    endgenerate

    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    logic signed [AW-1:0]     r_acc;
    logic [LOG2N-1:0]         r_cnt;
    logic signed [OWIDTH-1:0] r_data;
    logic                     r_valid;

    logic signed [AW:0]       w_sum;
    logic signed [AW-1:0]     w_total;
    logic signed [OWIDTH-1:0] w_result;
    logic                     w_unused_msb;
    logic                     w_last;
    logic                     w_accept;
    logic                     w_dump;

    signed_adder #(
        .AWIDTH(AW),
        .BWIDTH(IWIDTH)
    ) u_adder (
        .i_a  (r_acc),
        .i_b  (i_data),
        .o_sum(w_sum)
    );

    // N samples of IWIDTH bits never exceed AW bits, so the carry bit is dropped.
    assign w_total      = w_sum[AW-1:0];
    assign w_unused_msb = w_sum[AW];

`ifdef SIGNED_ACC_DUMP_MEAN_EN
    localparam logic signed [AW:0] RND = (AW+1)'(1) << (LOG2N-1);
    logic signed [AW:0] w_rnd;
    logic [LOG2N:0]     w_unused_rnd;

    assign w_rnd        = {w_total[AW-1], w_total} + RND;
    assign w_result     = w_rnd[LOG2N +: IWIDTH];
    assign w_unused_rnd = {w_rnd[AW], w_rnd[LOG2N-1:0]};
`else
    assign w_result = w_total;
`endif

    assign w_last   = (r_cnt == CNT_LAST);
    // Stall only when a dump would overwrite a result nobody has taken yet.
    assign o_ready  = !(w_last && r_valid && !i_ready);
    assign w_accept = i_valid && o_ready;
    assign w_dump   = w_accept && w_last && !i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear || w_dump) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_total;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_dump) begin
            r_data  <= w_result;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_signed_acc_dump.sv
// Directed bench for signed_acc_dump with N=4; expectations follow SIGNED_ACC_DUMP_MEAN_EN.
module tb_signed_acc_dump;

    localparam int IW = 17;
    localparam int L2 = 2;
`ifdef SIGNED_ACC_DUMP_MEAN_EN
    localparam int OW = IW;
`else
    localparam int OW = IW + L2;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic signed [IW-1:0] i_data = '0;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic                 i_clear = 1'b0;
    logic signed [OW-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    signed_acc_dump #(
        .IWIDTH(IW),
        .LOG2N (L2)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_clear(i_clear),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    // Picks the hand-computed value for the build: full sum or rounded mean.
    function automatic longint sel(input longint full_v, input longint mean_v);
`ifdef SIGNED_ACC_DUMP_MEAN_EN
        return mean_v;
`else
        return full_v;
`endif
    endfunction

    task automatic push(input int d);
        @(negedge i_clk);
        i_data  = IW'(d);
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_ready", o_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic full sum / mean
        push(100); push(200); push(-50);
        chk("basic_pre_valid", o_valid, 0);
        push(7);
        chk("basic_valid", o_valid, 1);
        chk("basic_data",  o_data, sel(257, 64));
        idle_cycle();
        chk("basic_consumed", o_valid, 0);

        push(-1); push(-1); push(-1); push(-2);
        chk("neg_valid", o_valid, 1);
        chk("neg_data",  o_data, sel(-5, -1));

        for (int k = 0; k < 4; k++) push(-65536);
        chk("min_data", o_data, sel(-262144, -65536));
        for (int k = 0; k < 4; k++) push(65535);
        chk("max_data", o_data, sel(262140, 65535));
        idle_cycle();
        chk("max_consumed", o_valid, 0);

        // Backpressure: 8 back-to-back samples with i_ready low
        i_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = IW'((k < 4) ? (k + 1) : (10 * (k - 3)));
            @(posedge i_clk);
            #1;
            if (k >= 3) begin
                chk("bp_first_valid", o_valid, 1);
                chk("bp_first_data",  o_data, sel(10, 3));
            end
        end
        @(negedge i_clk);
        i_data = IW'(40);
        chk("bp_stall_ready", o_ready, 0);
        @(posedge i_clk);
        #1;
        chk("bp_stall_data", o_data, sel(10, 3));
        @(negedge i_clk);
        i_ready = 1'b1;
        #1;
        chk("bp_release_ready", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        chk("bp_second_valid", o_valid, 1);
        chk("bp_second_data",  o_data, sel(100, 25));
        idle_cycle();
        chk("bp_drained", o_valid, 0);

        // Clear drops the partial block and the coincident sample
        push(5); push(6); push(7);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = IW'(8);
        i_clear = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        chk("clr_no_dump", o_valid, 0);
        push(1); push(2); push(3);
        chk("clr_pre_valid", o_valid, 0);
        push(4);
        chk("clr_valid", o_valid, 1);
        chk("clr_data",  o_data, sel(10, 3));

        // Async reset with a partial block and a pending result
        i_ready = 1'b0;
        push(9); push(9); push(9); push(9);
        push(9); push(9);
        chk("rst_pending", o_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data",  o_data, 0);
        chk("arst_ready", o_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        push(3); push(5); push(7);
        chk("post_rst_pre_valid", o_valid, 0);
        push(9);
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_data",  o_data, sel(24, 6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
